// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings for the multiply/divide issue controller: E-stage MD kinds,
// MD unit opcodes, controller states and the busy-wait timeout.
package md_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    KindNone  = 4'd0,
    KindMult  = 4'd1,
    KindMultu = 4'd2,
    KindDiv   = 4'd3,
    KindDivu  = 4'd4,
    KindMthi  = 4'd5,
    KindMtlo  = 4'd6,
    KindMfhi  = 4'd7,
    KindMflo  = 4'd8
  } md_kind_e;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } md_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } md_state_e;

  localparam int unsigned Timeout = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Issues mult/div/mthi/mtlo from E to the MD unit, stalls D while the unit is
// busy, returns mfhi/mflo data, and tracks protocol errors and retired ops.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_use,
  input  logic [3:0]  e_kind,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  output logic        md_start,
  output logic        md_if_mthi,
  output logic        md_if_mtlo,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_busy,
  input  logic [31:0] md_high,
  input  logic [31:0] md_low,
  output logic        stall_d,
  output logic [31:0] e_mf_data,
  output logic        md_err,
  output logic [15:0] op_count
);

  md_state_e   state_q, state_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;

  logic        kind_md;     // mult/multu/div/divu
  logic        kind_issue;  // anything that needs the unit: kinds 1-6
  logic [1:0]  kind_op;

  always_comb begin
    kind_md = 1'b0;
    kind_op = OpMult;
    case (e_kind)
      KindMult:  begin kind_md = 1'b1; kind_op = OpMult;  end
      KindMultu: begin kind_md = 1'b1; kind_op = OpMultu; end
      KindDiv:   begin kind_md = 1'b1; kind_op = OpDiv;   end
      KindDivu:  begin kind_md = 1'b1; kind_op = OpDivu;  end
      default:   ;
    endcase
    kind_issue = kind_md || (e_kind == KindMthi) || (e_kind == KindMtlo);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (kind_md) begin
          state_d = StWait;
          wcnt_d  = '0;
        end
      end
      StWait: begin
        wcnt_d = wcnt_q + 5'd1;
        // Issues arriving while busy are dropped and flagged.
        if (kind_issue) err_d = 1'b1;
        if (!md_busy && (wcnt_q == 5'd0)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (!md_busy) begin
          state_d = StIdle;
          count_d = sat_inc16(count_q);
        end else if (wcnt_d == 5'(Timeout)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    md_start   = !reset && (state_q == StIdle) && kind_md;
    md_if_mthi = !reset && (state_q == StIdle) && (e_kind == KindMthi);
    md_if_mtlo = !reset && (state_q == StIdle) && (e_kind == KindMtlo);
    md_op      = kind_md ? kind_op : OpMult;
    stall_d    = !reset && d_md_use && ((state_q == StWait) || kind_md);
    md_a       = e_rs;
    md_b       = e_rt;
    md_err     = err_q;
    op_count   = count_q;
    e_mf_data  = '0;
    if (e_kind == KindMfhi) e_mf_data = md_high;
    else if (e_kind == KindMflo) e_mf_data = md_low;
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: idle-state vector table, directed multi-cycle
// sequences, and randomized traffic against a cycle-level reference model.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_md_use;
  logic [3:0]  e_kind;
  logic [31:0] e_rs, e_rt;
  logic        md_start, md_if_mthi, md_if_mtlo;
  logic [1:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_busy;
  logic [31:0] md_high, md_low;
  logic        stall_d;
  logic [31:0] e_mf_data;
  logic        md_err;
  logic [15:0] op_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_md_use   (d_md_use),
    .e_kind     (e_kind),
    .e_rs       (e_rs),
    .e_rt       (e_rt),
    .md_start   (md_start),
    .md_if_mthi (md_if_mthi),
    .md_if_mtlo (md_if_mtlo),
    .md_op      (md_op),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_busy    (md_busy),
    .md_high    (md_high),
    .md_low     (md_low),
    .stall_d    (stall_d),
    .e_mf_data  (e_mf_data),
    .md_err     (md_err),
    .op_count   (op_count)
  );

  typedef struct {
    logic [3:0]  kind;
    logic        d_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        exp_start;
    logic [1:0]  exp_op;
    logic        exp_mthi;
    logic        exp_mtlo;
    logic        exp_stall;
    logic [31:0] exp_mf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] k, input logic du, input logic [31:0] hi,
                              input logic [31:0] lo, input logic st, input logic [1:0] op,
                              input logic th, input logic tl, input logic sd,
                              input logic [31:0] mf);
    vec_t v;
    v.kind = k; v.d_use = du; v.hi = hi; v.lo = lo; v.exp_start = st; v.exp_op = op;
    v.exp_mthi = th; v.exp_mtlo = tl; v.exp_stall = sd; v.exp_mf = mf;
    return v;
  endfunction

  task automatic drive(input logic [3:0] k, input logic du, input logic busy);
    @(negedge clk);
    e_kind = k;
    d_md_use = du;
    md_busy = busy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    e_kind = 4'd0;
    d_md_use = 1'b0;
    md_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model state: is an operation outstanding, cycles waited so far.
  bit m_fl;
  int m_w;
  bit m_err;
  int m_cnt;

  task automatic run_random(input int cycles);
    bit is_md;
    m_fl = 0; m_w = 0; m_err = 0; m_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      e_kind   = 4'($urandom_range(0, 15));
      d_md_use = 1'($urandom_range(0, 1));
      md_busy  = ($urandom_range(0, 9) < 8);
      e_rs = $urandom; e_rt = $urandom; md_high = $urandom; md_low = $urandom;
      #1;
      is_md = (e_kind >= 4'd1) && (e_kind <= 4'd4);
      chk("rnd_start", md_start, !m_fl && is_md);
      if (!m_fl && is_md) chk("rnd_op", md_op, e_kind - 4'd1);
      chk("rnd_mthi", md_if_mthi, !m_fl && (e_kind == 4'd5));
      chk("rnd_mtlo", md_if_mtlo, !m_fl && (e_kind == 4'd6));
      chk("rnd_stall", stall_d, d_md_use && (m_fl || is_md));
      chk("rnd_mf", e_mf_data, (e_kind == 4'd7) ? md_high : (e_kind == 4'd8) ? md_low : 32'd0);
      chk("rnd_a", md_a, e_rs);
      chk("rnd_b", md_b, e_rt);
      chk("rnd_err", md_err, m_err);
      chk("rnd_cnt", op_count, m_cnt);
      if (!m_fl) begin
        if (is_md) begin m_fl = 1; m_w = 0; end
      end else begin
        if (e_kind >= 4'd1 && e_kind <= 4'd6) m_err = 1;
        if (!md_busy) begin
          if (m_w == 0) m_err = 1;
          else if (m_cnt < 65535) m_cnt++;
          m_fl = 0;
        end else if (m_w + 1 >= 16) begin
          m_err = 1;
          m_fl = 0;
        end else begin
          m_w++;
        end
      end
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(4'd0,  1'b1, 32'h1,        32'h2,        0, 2'd0, 0, 0, 0, 32'd0);
    tbl[1]  = mk(4'd1,  1'b0, 32'h1,        32'h2,        1, 2'd0, 0, 0, 0, 32'd0);
    tbl[2]  = mk(4'd2,  1'b1, 32'h1,        32'h2,        1, 2'd1, 0, 0, 1, 32'd0);
    tbl[3]  = mk(4'd3,  1'b1, 32'h1,        32'h2,        1, 2'd2, 0, 0, 1, 32'd0);
    tbl[4]  = mk(4'd4,  1'b0, 32'h1,        32'h2,        1, 2'd3, 0, 0, 0, 32'd0);
    tbl[5]  = mk(4'd5,  1'b1, 32'h1,        32'h2,        0, 2'd0, 1, 0, 0, 32'd0);
    tbl[6]  = mk(4'd6,  1'b1, 32'h1,        32'h2,        0, 2'd0, 0, 1, 0, 32'd0);
    tbl[7]  = mk(4'd7,  1'b1, 32'h1234,     32'h5678,     0, 2'd0, 0, 0, 0, 32'h1234);
    tbl[8]  = mk(4'd8,  1'b1, 32'h1234,     32'hCAFEF00D, 0, 2'd0, 0, 0, 0, 32'hCAFEF00D);
    tbl[9]  = mk(4'd12, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 2'd0, 0, 0, 0, 32'd0);
    tbl[10] = mk(4'd15, 1'b1, 32'hAAAA5555, 32'h5555AAAA, 0, 2'd0, 0, 0, 0, 32'd0);

    // Reset state, with inputs that would otherwise issue and stall.
    reset = 1'b1; e_kind = 4'd1; d_md_use = 1'b1; md_busy = 1'b1;
    e_rs = '0; e_rt = '0; md_high = '0; md_low = '0;
    #1;
    chk("rst_start", md_start, 0);
    chk("rst_stall", stall_d, 0);
    chk("rst_err", md_err, 0);
    chk("rst_cnt", op_count, 0);
    e_kind = 4'd5; #1;
    chk("rst_mthi", md_if_mthi, 0);
    do_reset();

    // Idle-state combinational table; kind returns to NONE before each edge.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      e_kind = tbl[i].kind; d_md_use = tbl[i].d_use; md_busy = 1'b1;
      md_high = tbl[i].hi; md_low = tbl[i].lo; e_rs = $urandom; e_rt = $urandom;
      #1;
      chk("tbl_start", md_start, tbl[i].exp_start);
      if (tbl[i].exp_start) chk("tbl_op", md_op, tbl[i].exp_op);
      chk("tbl_mthi", md_if_mthi, tbl[i].exp_mthi);
      chk("tbl_mtlo", md_if_mtlo, tbl[i].exp_mtlo);
      chk("tbl_stall", stall_d, tbl[i].exp_stall);
      chk("tbl_mf", e_mf_data, tbl[i].exp_mf);
      chk("tbl_a", md_a, e_rs);
      chk("tbl_b", md_b, e_rt);
      #1 e_kind = 4'd0;
    end

    // MULT 7 x -3, busy five cycles, retires once.
    do_reset();
    drive(4'd1, 1'b0, 1'b0); e_rs = 32'd7; e_rt = 32'hFFFFFFFD; #1;
    chk("mult_start", md_start, 1);
    chk("mult_op", md_op, 2'b00);
    chk("mult_a", md_a, 32'd7);
    chk("mult_b", md_b, 32'hFFFFFFFD);
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 1'b1, 1'b1); #1;
      chk("mult_wait_start", md_start, 0);
      chk("mult_wait_stall", stall_d, 1);
    end
    drive(4'd0, 1'b1, 1'b0); #1;
    chk("mult_last_stall", stall_d, 1);
    drive(4'd0, 1'b1, 1'b0); #1;
    chk("mult_done_stall", stall_d, 0);
    chk("mult_cnt", op_count, 1);
    chk("mult_err", md_err, 0);

    // DIVU with D waiting on the unit: stall on issue and all busy cycles.
    do_reset();
    drive(4'd4, 1'b1, 1'b0); #1;
    chk("divu_op", md_op, 2'b11);
    chk("divu_issue_stall", stall_d, 1);
    for (int i = 0; i < 10; i++) begin
      drive(4'd0, 1'b1, 1'b1); #1;
      chk("divu_busy_stall", stall_d, 1);
    end
    drive(4'd0, 1'b1, 1'b0); #1;
    drive(4'd0, 1'b1, 1'b0); #1;
    chk("divu_after_stall", stall_d, 0);
    chk("divu_cnt", op_count, 1);

    // mthi while busy is dropped and flagged from the next edge.
    do_reset();
    drive(4'd2, 1'b0, 1'b0);
    drive(4'd5, 1'b0, 1'b1); #1;
    chk("drop_mthi", md_if_mthi, 0);
    chk("drop_err_before", md_err, 0);
    drive(4'd0, 1'b0, 1'b1); #1;
    chk("drop_err_after", md_err, 1);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0); #1;
    chk("drop_cnt", op_count, 1);

    // Busy stuck high: timeout after sixteen waiting cycles, no retirement.
    do_reset();
    drive(4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(4'd0, 1'b1, 1'b1); #1;
      if (i == 15) begin
        chk("tmo_err_pre", md_err, 0);
        chk("tmo_stall_pre", stall_d, 1);
      end
      if (i == 16) begin
        chk("tmo_err", md_err, 1);
        chk("tmo_idle", stall_d, 0);
      end
    end
    chk("tmo_cnt", op_count, 0);

    // Unit never accepts: busy low on the first waiting cycle.
    do_reset();
    drive(4'd1, 1'b1, 1'b0);
    drive(4'd0, 1'b1, 1'b0);
    drive(4'd0, 1'b1, 1'b0); #1;
    chk("noacc_err", md_err, 1);
    chk("noacc_idle", stall_d, 0);
    chk("noacc_cnt", op_count, 0);

    // Reset mid-wait, between edges, after one retired op and an error.
    do_reset();
    drive(4'd1, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd1, 1'b0, 1'b0);
    drive(4'd6, 1'b0, 1'b1);
    drive(4'd1, 1'b1, 1'b1); #1;
    chk("abort_pre_cnt", op_count, 1);
    chk("abort_pre_err", md_err, 1);
    chk("abort_pre_stall", stall_d, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_stall", stall_d, 0);
    chk("abort_start", md_start, 0);
    chk("abort_cnt", op_count, 0);
    chk("abort_err", md_err, 0);
    @(negedge clk);
    reset = 1'b0; e_kind = 4'd0; md_busy = 1'b0; #1;
    chk("abort_idle", stall_d, 0);
    chk("abort_cnt_post", op_count, 0);

    for (int b = 0; b < 3; b++) begin
      do_reset();
      run_random(1500);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port d_md_use, input, 1 bit: the D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-004 SHALL have port e_kind, input, 4 bits: E-stage MD kind (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as NONE).
REQ-005 SHALL have ports e_rs and e_rt, input, 32 bits each: E-stage forwarded operands.
REQ-006 SHALL have ports md_start, md_if_mthi and md_if_mtlo, output, 1 bit each; md_op, output, 2 bits; md_a and md_b, output, 32 bits each: drive the MD unit.
REQ-007 SHALL have port md_busy, input, 1 bit, and ports md_high and md_low, input, 32 bits each: MD unit status and HI/LO.
REQ-008 SHALL have port stall_d, output, 1 bit: freeze PC and F/D and insert a bubble into E.
REQ-009 SHALL have port e_mf_data, output, 32 bits: mfhi/mflo result for E.
REQ-010 SHALL have ports md_err, output, 1 bit: sticky protocol error; and op_count, output, 16 bits: retired mult/div count.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT, plus a 5-bit wait counter wcnt.
REQ-012 SHALL assert md_start combinationally only when state=IDLE and e_kind is in 1-4, with md_op = e_kind-1 (00 mult, 01 multu, 10 div, 11 divu).
REQ-013 SHALL drive md_a=e_rs and md_b=e_rt unconditionally.
REQ-014 SHALL assert md_if_mthi (md_if_mtlo) only when state=IDLE and e_kind=5 (6).
REQ-015 SHALL transition IDLE->WAIT on an edge where md_start=1, clearing wcnt to 0.
REQ-016 SHALL, in WAIT, increment wcnt every cycle and transition WAIT->IDLE on the first edge that samples md_busy=0.
REQ-017 SHALL increment op_count on each WAIT->IDLE transition, saturating at 16'hFFFF.
REQ-018 SHALL set stall_d = d_md_use AND (state=WAIT OR e_kind in 1-4); the first cycle of a mult/div in E therefore already stalls D.
REQ-019 SHALL set e_mf_data = md_high for e_kind=7, md_low for e_kind=8, and 0 otherwise.
REQ-020 SHALL set md_err and hold it until reset when any of the following occurs:
  - e_kind in 1-6 while state=WAIT (the issue is dropped: no md_start, md_if_mthi or md_if_mtlo);
  - wcnt reaches 16 while in WAIT (timeout);
  - md_busy=0 on the first WAIT cycle (the unit did not accept the operation).
REQ-021 SHALL, on a timeout, force WAIT->IDLE and SHALL NOT increment op_count.
REQ-022 SHALL, on a missing-accept error, return to IDLE and SHALL NOT increment op_count.
REQ-023 SHALL, on e_kind 7/8 in WAIT, still drive e_mf_data (REQ-018 prevents this legally; no error).

Reset
REQ-024 SHALL, on reset assertion, immediately force state=IDLE, wcnt=0, md_err=0 and op_count=0, independent of clk.
REQ-025 SHALL, while reset is high, hold all control outputs (md_start, md_if_mthi, md_if_mtlo, stall_d) at 0.
REQ-026 SHALL treat reset during WAIT as an abort: the return is to IDLE with no count increment.

Structure
REQ-027 SHALL place the e_kind encodings, the md_op encodings, the timeout constant (16) and the state encodings in the shared pipeline package.
REQ-028 SHALL be a single module; the op_count saturating counter MAY be split out as sub-module sat_counter16.

Verification
REQ-029 SHALL cover: e_kind=1, e_rs=7, e_rt=-3, md_busy high for 5 cycles -> md_start for one cycle with md_op=00, WAIT for 5 cycles, op_count=1.
REQ-030 SHALL cover: DIVU issued, then d_md_use=1 on the next cycle -> stall_d=1 on the issue cycle and all 10 busy cycles, then 0 after md_busy falls.
REQ-031 SHALL cover: e_kind=7 with md_high=32'h1234 while IDLE -> e_mf_data=32'h1234 and no stall.
REQ-032 SHALL cover: e_kind=5 forced while in WAIT -> md_if_mthi stays 0 and md_err=1 from the next edge.
REQ-033 SHALL cover: md_busy held at 1 for 20 cycles -> md_err=1 at wcnt=16, state returns to IDLE, op_count unchanged.
REQ-034 SHALL cover: reset pulsed mid-WAIT between clock edges -> state=IDLE and outputs low immediately, with op_count=0.
